// File: rtl/mx8_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit 8-to-1 mux among 8 requesters.
// Each grant is held for BURST beats and the mux output is captured with a source tag.
module mx8_rr_arbiter #(
  parameter int unsigned BURST = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [3:0] mux_y,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic [7:0] grant,
  output logic [3:0] y_q,
  output logic [2:0] tag,
  output logic       valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // BURST is legal in 1..15 so that BURST-1 fits the 4-bit beat counter
  localparam logic [3:0] BURST_M1 = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] y_d;
  logic [2:0] tag_q, tag_d;
  logic       valid_q, valid_d;

  logic [2:0] next_ptr_s;
  logic [3:0] pick_idle_s;
  logic [3:0] pick_end_s;
  logic       burst_end_s;

  // {found, index} of the first set bit of r scanning p, p+1, ... p+7 modulo 8
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] one_hot(input logic [2:0] idx);
    return 8'(8'd1 << idx);
  endfunction

  // Candidate winners for a fresh arbitration and for a burst-end re-arbitration
  always_comb begin
    next_ptr_s  = sel_q + 3'd1;
    pick_idle_s = rr_pick(req, ptr_q);
    pick_end_s  = rr_pick(req, next_ptr_s);
  end

  // Next-state logic for the sequencer, grant, beat counter and capture path
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    y_d         = y_q;
    tag_d       = tag_q;
    valid_d     = 1'b0;
    burst_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_idle_s[3]) begin
          state_d = GRANT;
          grant_d = one_hot(pick_idle_s[2:0]);
          sel_d   = pick_idle_s[2:0];
          cnt_d   = BURST_M1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A dropped request ends the burst early without capturing
        if (req[sel_q]) begin
          y_d     = mux_y;
          tag_d   = sel_q;
          valid_d = 1'b1;
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            burst_end_s = 1'b1;
          end
        end else begin
          burst_end_s = 1'b1;
        end
        if (burst_end_s) begin
          ptr_d = next_ptr_s;
          if (pick_end_s[3]) begin
            state_d = GRANT;
            grant_d = one_hot(pick_end_s[2:0]);
            sel_d   = pick_end_s[2:0];
            cnt_d   = BURST_M1;
          end else begin
            state_d = IDLE;
            grant_d = 8'h00;
            sel_d   = 3'b000;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
        sel_d   = 3'b000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      grant_q <= 8'h00;
      sel_q   <= 3'b000;
      y_q     <= 4'h0;
      tag_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign s2    = sel_q[2];
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign tag   = tag_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mx8_rr_arbiter.sv
// Directed bench: one arbiter instance per burst length, each scenario a task.
module tb_mx8_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // BURST = 1 instance
  logic [7:0] req1 = 8'h00;
  logic [3:0] my1;
  logic a2, a1, a0, v1;
  logic [7:0] g1;
  logic [3:0] y1;
  logic [2:0] t1;
  // BURST = 2 instance
  logic [7:0] req2 = 8'h00;
  logic [3:0] my2 = 4'h0;
  logic b2, b1, b0, v2;
  logic [7:0] g2;
  logic [3:0] y2;
  logic [2:0] t2;
  // BURST = 3 instance
  logic [7:0] req3 = 8'h00;
  logic [3:0] my3 = 4'h0;
  logic c2, c1, c0, v3;
  logic [7:0] g3;
  logic [3:0] y3;
  logic [2:0] t3;
  // BURST = 4 instance
  logic [7:0] req4 = 8'h00;
  logic [3:0] my4 = 4'h0;
  logic d2, d1, d0, v4;
  logic [7:0] g4;
  logic [3:0] y4;
  logic [2:0] t4;

  // External mux for the BURST=1 instance: input i carries i+9
  assign my1 = {1'b0, a2, a1, a0} + 4'd9;

  mx8_rr_arbiter #(.BURST(1)) u1 (.clk(clk), .reset(reset), .req(req1), .mux_y(my1),
    .s2(a2), .s1(a1), .s0(a0), .grant(g1), .y_q(y1), .tag(t1), .valid(v1));
  mx8_rr_arbiter #(.BURST(2)) u2 (.clk(clk), .reset(reset), .req(req2), .mux_y(my2),
    .s2(b2), .s1(b1), .s0(b0), .grant(g2), .y_q(y2), .tag(t2), .valid(v2));
  mx8_rr_arbiter #(.BURST(3)) u3 (.clk(clk), .reset(reset), .req(req3), .mux_y(my3),
    .s2(c2), .s1(c1), .s0(c0), .grant(g3), .y_q(y3), .tag(t3), .valid(v3));
  mx8_rr_arbiter #(.BURST(4)) u4 (.clk(clk), .reset(reset), .req(req4), .mux_y(my4),
    .s2(d2), .s1(d1), .s0(d0), .grant(g4), .y_q(y4), .tag(t4), .valid(v4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req1 = 8'h00; req2 = 8'h00; req3 = 8'h00; req4 = 8'h00;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req2 = 8'h20;
    my2 = 4'h7;
    step();
    checks++;
    if (g2 !== 8'h20 || {b2, b1, b0} !== 3'b101) begin
      errors++; $display("FAIL rst_grant5: grant=%h sel=%b need 20/101", g2, {b2, b1, b0});
    end
    step();
    checks++;
    if (v2 !== 1'b1 || y2 !== 4'h7 || t2 !== 3'd5) begin
      errors++; $display("FAIL rst_beat: v=%b y=%h tag=%0d need 1/7/5", v2, y2, t2);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (g2 !== 8'h00 || {b2, b1, b0} !== 3'b000 || v2 !== 1'b0 || y2 !== 4'h0 || t2 !== 3'd0) begin
      errors++; $display("FAIL rst_async: grant=%h sel=%b v=%b y=%h tag=%0d need all 0",
        g2, {b2, b1, b0}, v2, y2, t2);
    end
    req2 = 8'h00;
    reset = 1'b0;
    step();
    checks++;
    if (g2 !== 8'h00 || {b2, b1, b0} !== 3'b000 || v2 !== 1'b0 || y2 !== 4'h0 || t2 !== 3'd0) begin
      errors++; $display("FAIL rst_idle: grant=%h sel=%b v=%b y=%h tag=%0d need all 0",
        g2, {b2, b1, b0}, v2, y2, t2);
    end
  endtask

  task automatic test_single();
    do_reset();
    req2 = 8'h08;
    my2 = 4'hA;
    step();
    checks++;
    if (g2 !== 8'h08 || {b2, b1, b0} !== 3'b011 || v2 !== 1'b0) begin
      errors++; $display("FAIL single_grant: grant=%h sel=%b v=%b need 08/011/0", g2, {b2, b1, b0}, v2);
    end
    step();
    checks++;
    if (v2 !== 1'b1 || y2 !== 4'hA || t2 !== 3'd3 || g2 !== 8'h08) begin
      errors++; $display("FAIL single_beat1: v=%b y=%h tag=%0d grant=%h need 1/A/3/08", v2, y2, t2, g2);
    end
    my2 = 4'hB;
    step();
    checks++;
    if (v2 !== 1'b1 || y2 !== 4'hB || t2 !== 3'd3 || g2 !== 8'h08 || {b2, b1, b0} !== 3'b011) begin
      errors++; $display("FAIL single_beat2_regrant: v=%b y=%h tag=%0d grant=%h need 1/B/3/08", v2, y2, t2, g2);
    end
    req2 = 8'h00;
    step();
    checks++;
    if (v2 !== 1'b0 || g2 !== 8'h00 || {b2, b1, b0} !== 3'b000 || y2 !== 4'hB || t2 !== 3'd3) begin
      errors++; $display("FAIL single_release: v=%b grant=%h sel=%b y=%h tag=%0d need 0/00/000/B/3",
        v2, g2, {b2, b1, b0}, y2, t2);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] gi;
    logic [2:0] ti;
    do_reset();
    req1 = 8'hFF;
    for (int i = 0; i < 11; i++) begin
      step();
      gi = 3'(i);
      ti = 3'(i - 1);
      checks++;
      if (g1 !== 8'(8'd1 << gi) || {a2, a1, a0} !== gi) begin
        errors++; $display("FAIL rot_grant%0d: grant=%h sel=%b need index %0d", i, g1, {a2, a1, a0}, gi);
      end
      if (i >= 1) begin
        checks++;
        if (v1 !== 1'b1 || t1 !== ti || y1 !== ({1'b0, ti} + 4'd9)) begin
          errors++; $display("FAIL rot_beat%0d: v=%b tag=%0d y=%h need 1/%0d", i, v1, t1, y1, ti);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req4 = 8'h44;
    my4 = 4'h5;
    step();
    checks++;
    if (g4 !== 8'h04 || {d2, d1, d0} !== 3'b010) begin
      errors++; $display("FAIL early_grant2: grant=%h sel=%b need 04/010", g4, {d2, d1, d0});
    end
    step();
    checks++;
    if (v4 !== 1'b1 || y4 !== 4'h5 || t4 !== 3'd2 || g4 !== 8'h04) begin
      errors++; $display("FAIL early_beat1: v=%b y=%h tag=%0d grant=%h need 1/5/2/04", v4, y4, t4, g4);
    end
    req4 = 8'h40;
    my4 = 4'hE;
    step();
    checks++;
    if (v4 !== 1'b0 || y4 !== 4'h5 || t4 !== 3'd2 || g4 !== 8'h40 || {d2, d1, d0} !== 3'b110) begin
      errors++; $display("FAIL early_drop: v=%b y=%h tag=%0d grant=%h sel=%b need 0/5/2/40/110",
        v4, y4, t4, g4, {d2, d1, d0});
    end
    step();
    checks++;
    if (v4 !== 1'b1 || y4 !== 4'hE || t4 !== 3'd6) begin
      errors++; $display("FAIL early_src6: v=%b y=%h tag=%0d need 1/E/6", v4, y4, t4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req1 = 8'h40;
    step();
    checks++;
    if (g1 !== 8'h40) begin
      errors++; $display("FAIL wrap_g6: grant=%h need 40", g1);
    end
    req1 = 8'h81;
    step();
    checks++;
    if (g1 !== 8'h80 || {a2, a1, a0} !== 3'b111 || v1 !== 1'b0) begin
      errors++; $display("FAIL wrap_g7: grant=%h sel=%b v=%b need 80/111/0", g1, {a2, a1, a0}, v1);
    end
    step();
    checks++;
    if (g1 !== 8'h01 || {a2, a1, a0} !== 3'b000 || v1 !== 1'b1 || t1 !== 3'd7 || y1 !== 4'h0) begin
      errors++; $display("FAIL wrap_g0: grant=%h sel=%b v=%b tag=%0d y=%h need 01/000/1/7/0",
        g1, {a2, a1, a0}, v1, t1, y1);
    end
    req1 = 8'h00;
    step();
    checks++;
    if (g1 !== 8'h00 || {a2, a1, a0} !== 3'b000 || v1 !== 1'b0) begin
      errors++; $display("FAIL wrap_idle: grant=%h sel=%b v=%b need 00/000/0", g1, {a2, a1, a0}, v1);
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    req3 = 8'h10;
    my3 = 4'h3;
    step();
    checks++;
    if (g3 !== 8'h10 || {c2, c1, c0} !== 3'b100) begin
      errors++; $display("FAIL late_grant4: grant=%h sel=%b need 10/100", g3, {c2, c1, c0});
    end
    req3 = 8'h12;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (v3 !== 1'b1 || t3 !== 3'd4 || y3 !== 4'h3 || g3 !== ((i < 3) ? 8'h10 : 8'h02)) begin
        errors++; $display("FAIL late_beat%0d: v=%b tag=%0d y=%h grant=%h need 1/4/3/%h",
          i, v3, t3, y3, g3, (i < 3) ? 8'h10 : 8'h02);
      end
    end
    my3 = 4'hC;
    step();
    checks++;
    if (v3 !== 1'b1 || t3 !== 3'd1 || y3 !== 4'hC || {c2, c1, c0} !== 3'b001) begin
      errors++; $display("FAIL late_src1: v=%b tag=%0d y=%h sel=%b need 1/1/C/001", v3, t3, y3, {c2, c1, c0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_wrap();
    test_late_arrival();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
